amp_mailbox: RTL

Parametrised inter-processor mailbox between the HPS lightweight bridge (master side) and NUM_CH Nios II cores (remote side), generalising the single one-bit `to_master` doorbell PIO into a multi-channel block. Each channel has a master-to-remote message FIFO and a remote-to-master doorbell with sticky pending status. A maskable interrupt is raised to the HPS. The block sits in the Qsys system as an Avalon-MM slave, with one conduit per Nios core.

---
 rtl/amp_mailbox_pkg.sv | 50 +++++
 rtl/amp_mailbox_if.sv | 21 ++
 rtl/amp_mailbox_fifo.sv | 66 ++++++
 rtl/amp_mailbox.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/amp_mailbox_pkg.sv
// Shared register map constants and address decode for the inter-processor mailbox.
package amp_mailbox_pkg;

   localparam int unsigned REG_IRQ_PEND     = 0;
   localparam int unsigned REG_IRQ_EN       = 1;
   localparam int unsigned REG_OVF          = 2;
   localparam int unsigned CH_BASE          = 4;

   localparam int unsigned STATUS_LEVEL_W   = 16;
   localparam int unsigned STATUS_EMPTY_BIT = 16;
   localparam int unsigned STATUS_FULL_BIT  = 17;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_PEND,
      SEL_EN,
      SEL_OVF,
      SEL_TXDATA,
      SEL_STATUS
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e   sel;
      logic [2:0] ch;
   } addr_dec_t;

   // Map a word address onto a register selector and channel index.
   // Per-channel registers come in TXDATA/STATUS pairs starting at CH_BASE;
   // anything beyond the last channel decodes to SEL_NONE.
   function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                             input int unsigned num_ch);
      addr_dec_t   d;
      logic [31:0] off;
      d.sel = SEL_NONE;
      d.ch  = '0;
      off   = addr - CH_BASE;
      if (addr == REG_IRQ_PEND) begin
         d.sel = SEL_PEND;
      end else if (addr == REG_IRQ_EN) begin
         d.sel = SEL_EN;
      end else if (addr == REG_OVF) begin
         d.sel = SEL_OVF;
      end else if ((addr >= CH_BASE) && ((off >> 1) < num_ch)) begin
         d.ch  = off[3:1];
         d.sel = off[0] ? SEL_STATUS : SEL_TXDATA;
      end
      return d;
   endfunction

endpackage

// File: rtl/amp_mailbox_if.sv
// Avalon-MM slave bus bundle between the HPS lightweight bridge and the mailbox.
interface amp_mailbox_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, avs_readdatavalid
   );
endinterface

// File: rtl/amp_mailbox_fifo.sv
// First-word-fall-through FIFO for one master-to-remote message channel.
module amp_mailbox_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;

   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !w_empty;
   // A pop in the same cycle frees the head slot, so a push at full still lands.
   assign w_push_ok = i_push && (!w_full || w_pop_ok);

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_ovf   = i_push && !w_push_ok;

   // Storage array write port.
   // NOTE: the data array has no reset; empty/full come from the pointers,
   // so stale contents are never observable and the array can map to RAM.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   // Read and write pointers; reset discards all queued words.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/amp_mailbox.sv
// Multi-channel HPS <-> Nios II mailbox: message FIFOs, doorbells and maskable IRQ.
module amp_mailbox
   import amp_mailbox_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 5
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset_n,
   amp_mailbox_if.slave               avs,
   output logic [NUM_CH*DATA_W-1:0]   ch_data,
   output logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH-1:0]          ch_ready,
   input  logic [NUM_CH-1:0]          to_master_export,
   output logic                       irq
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] w_addr;
   addr_dec_t         w_dec;

   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_ovf_pulse;
   logic [LVL_W-1:0]  w_level [NUM_CH];

   logic [NUM_CH-1:0] r_sync1;
   logic [NUM_CH-1:0] r_sync2;
   logic [NUM_CH-1:0] r_sync3;
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_en;
   logic [NUM_CH-1:0] r_ovf;
   logic              r_irq;
   logic [31:0]       r_rdata;
   logic              r_rvalid;

   logic [NUM_CH-1:0] w_db_rise;
   logic [NUM_CH-1:0] w_pend_clr;
   logic [NUM_CH-1:0] w_pend_kept;
   logic [NUM_CH-1:0] w_pend_next;
   logic [NUM_CH-1:0] w_ovf_clr;
   logic [NUM_CH-1:0] w_ovf_next;
   logic [NUM_CH-1:0] w_en_next;
   logic              w_irq_next;
   logic [31:0]       w_rdata;

   assign w_addr = avs.avs_address;
   assign w_dec  = decode_addr(32'(w_addr), NUM_CH);

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         logic [DATA_W-1:0] w_head;

         assign w_push[c] = avs.avs_write && (w_dec.sel == SEL_TXDATA) &&
                            (w_dec.ch == 3'(c));

         amp_mailbox_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .i_push  (w_push[c]),
            .i_data  (avs.avs_writedata[DATA_W-1:0]),
            .i_pop   (ch_ready[c]),
            .o_data  (w_head),
            .o_empty (w_empty[c]),
            .o_full  (w_full[c]),
            .o_level (w_level[c]),
            .o_ovf   (w_ovf_pulse[c])
         );

         assign ch_data[c*DATA_W +: DATA_W] = w_head;
         assign ch_valid[c]                 = !w_empty[c];
      end
   endgenerate

   // Rising edge of the synchronised doorbell; r_sync3 is the edge register.
   assign w_db_rise = r_sync2 & ~r_sync3;

   // Write-1-to-clear masks; a same-cycle set overrides the clear.
   assign w_pend_clr  = (avs.avs_write && (w_dec.sel == SEL_PEND)) ?
                        avs.avs_writedata[NUM_CH-1:0] : '0;
   assign w_ovf_clr   = (avs.avs_write && (w_dec.sel == SEL_OVF)) ?
                        avs.avs_writedata[NUM_CH-1:0] : '0;
   assign w_pend_kept = r_pend & ~w_pend_clr;
   assign w_pend_next = w_pend_kept | w_db_rise;
   assign w_ovf_next  = (r_ovf & ~w_ovf_clr) | w_ovf_pulse;
   assign w_en_next   = (avs.avs_write && (w_dec.sel == SEL_EN)) ?
                        avs.avs_writedata[NUM_CH-1:0] : r_en;

   // Register writes reach irq on the next edge, while a doorbell set is seen
   // only once IRQ_PEND holds it, so irq trails IRQ_PEND by one cycle.
   assign w_irq_next = |(w_pend_kept & w_en_next);

   // Read mux; STATUS reflects FIFO state before the sampling edge.
   // NOTE: every output is given a default first so no latch is inferred.
   always_comb begin
      w_rdata = '0;
      unique case (w_dec.sel)
         SEL_PEND: w_rdata[NUM_CH-1:0] = r_pend;
         SEL_EN:   w_rdata[NUM_CH-1:0] = r_en;
         SEL_OVF:  w_rdata[NUM_CH-1:0] = r_ovf;
         SEL_STATUS: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (w_dec.ch == 3'(i)) begin
                  w_rdata[LVL_W-1:0]       = w_level[i];
                  w_rdata[STATUS_EMPTY_BIT] = w_empty[i];
                  w_rdata[STATUS_FULL_BIT]  = w_full[i];
               end
            end
         end
         default: w_rdata = '0;
      endcase
   end

   // Synchronisers, status/control registers, irq and read response.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync3  <= '0;
         r_pend   <= '0;
         r_en     <= '0;
         r_ovf    <= '0;
         r_irq    <= 1'b0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_sync1  <= to_master_export;
         r_sync2  <= r_sync1;
         r_sync3  <= r_sync2;
         r_pend   <= w_pend_next;
         r_en     <= w_en_next;
         r_ovf    <= w_ovf_next;
         r_irq    <= w_irq_next;
         r_rvalid <= avs.avs_read;
         if (avs.avs_read) r_rdata <= w_rdata;
      end
   end

   assign avs.avs_readdata      = r_rdata;
   assign avs.avs_readdatavalid = r_rvalid;
   assign irq                   = r_irq;

endmodule
